cargador_serie_izq_der: RTL

Bit-serial front end for the left-to-right iterative comparison network. Accepts operand pairs one bit per handshake, assembles two N-bit words, and presents them in parallel to the network's A/B inputs. It then samples the network's combinational Zout once the words are stable, and returns the result through a valid/ready handshake. It sits directly upstream of the network and also registers the network's output.

---
 rtl/cargador_serie_izq_der_if.sv | 25 ++
 rtl/cargador_serie_izq_der.sv | 89 ++++++++
 2 files changed

// File: rtl/cargador_serie_izq_der_if.sv
// Handshake and word bus between the serial loader, its bit source, the comparison network and the result consumer.
interface cargador_serie_izq_der_if #(
  parameter int unsigned N = 3
);
  logic         in_valid;
  logic         in_a;
  logic         in_b;
  logic         in_ready;
  logic [N-1:0] A_out;
  logic [N-1:0] B_out;
  logic         z_in;
  logic         res_valid;
  logic         res_z;
  logic         res_ready;

  modport slave (
    input  in_valid, in_a, in_b, z_in, res_ready,
    output in_ready, A_out, B_out, res_valid, res_z
  );

  modport master (
    output in_valid, in_a, in_b, z_in, res_ready,
    input  in_ready, A_out, B_out, res_valid, res_z
  );
endinterface

// File: rtl/cargador_serie_izq_der.sv
// Bit-serial loader: assembles two N-bit words, presents them to the comparison network, registers its result.
// Define SERIE_LSB_PRIMERO_EN for LSB-first bit order (default is MSB first).
module cargador_serie_izq_der #(
  parameter int unsigned N = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  cargador_serie_izq_der_if.slave bus
);
  localparam int unsigned CW = $clog2(N + 1);

  typedef enum logic [1:0] {
    CARGA  = 2'd0,
    EVAL   = 2'd1,
    RESULT = 2'd2
  } state_t;

  state_t         state, state_next;
  logic [CW-1:0]  cnt;
  logic [N-1:0]   sa, sb, sa_next, sb_next;
  logic [N-1:0]   a_reg, b_reg;
  logic           res_valid_reg, res_z_reg;
  logic           accept, last;

  assign accept = bus.in_valid && (state == CARGA);
  assign last   = accept && (cnt == CW'(N - 1));

  always_comb begin
`ifdef SERIE_LSB_PRIMERO_EN
    sa_next = {bus.in_a, sa[N-1:1]};
    sb_next = {bus.in_b, sb[N-1:1]};
`else
    sa_next = {sa[N-2:0], bus.in_a};
    sb_next = {sb[N-2:0], bus.in_b};
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= CARGA;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      CARGA:   if (last) state_next = EVAL;
      EVAL:    state_next = RESULT;
      RESULT:  if (bus.res_ready) state_next = CARGA;
      default: state_next = CARGA;
    endcase
  end

  // Words are published from the shift-next value so the bit arriving on the final edge is included.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt           <= '0;
      sa            <= '0;
      sb            <= '0;
      a_reg         <= '0;
      b_reg         <= '0;
      res_valid_reg <= 1'b0;
      res_z_reg     <= 1'b0;
    end else begin
      if (accept) begin
        sa <= sa_next;
        sb <= sb_next;
        if (last) begin
          cnt   <= '0;
          a_reg <= sa_next;
          b_reg <= sb_next;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end
      if (state == EVAL) begin
        res_z_reg     <= bus.z_in;
        res_valid_reg <= 1'b1;
      end else if (state == RESULT && bus.res_ready) begin
        res_valid_reg <= 1'b0;
      end
    end
  end

  assign bus.in_ready  = (state == CARGA);
  assign bus.A_out     = a_reg;
  assign bus.B_out     = b_reg;
  assign bus.res_valid = res_valid_reg;
  assign bus.res_z     = res_z_reg;
endmodule
